// File: rtl/count_snapshot_unit.sv
`default_nettype none
//==============================================================================
// Module      : count_snapshot_unit
// Description : Samples the count of a slower, asynchronous 4-bit upstream
//               counter, filters glitches, tracks 15->0 wraps, flags skipped
//               counts and offers {wrap_count, q_acc} snapshots to a consumer
//               over a valid/ready handshake with one pending request slot.
//
// Ports       : clk         - rising-edge clock (>= 4x upstream counter clock)
//               clear       - synchronous active-high reset
//               q_in[3:0]   - upstream count, asynchronous, may glitch
//               cnt_clear   - upstream counter clear, asynchronous
//               snap_req    - one-cycle snapshot request
//               snap_ready  - consumer ready
//               snap_valid  - snapshot held and available
//               snap_data   - {wrap_count[7:0], q_acc[3:0]}
//               wrap_pulse  - one-cycle pulse on a natural 15->0 wrap
//               err_skip    - sticky: a non-consecutive count was accepted
//               overrun     - sticky: a snapshot request was dropped
//
// Revision    : 1.0 - initial release
//==============================================================================
module count_snapshot_unit (
    input  logic        clk,
    input  logic        clear,
    input  logic [3:0]  q_in,
    input  logic        cnt_clear,
    input  logic        snap_req,
    input  logic        snap_ready,
    output logic        snap_valid,
    output logic [11:0] snap_data,
    output logic        wrap_pulse,
    output logic        err_skip,
    output logic        overrun
);

    localparam int         c_CNT_W  = 4;
    localparam int         c_WRAP_W = 8;
    localparam int         c_SNAP_W = c_WRAP_W + c_CNT_W;

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_HOLD = 1'b1;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    //--------------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous count and clear
    //--------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_q_s1;
    logic [c_CNT_W-1:0] r_q_s2;
    logic               r_cc_s1;
    logic               r_cc_s2;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q_s1  <= '0;
            r_q_s2  <= '0;
            r_cc_s1 <= 1'b0;
            r_cc_s2 <= 1'b0;
        end else begin
            r_q_s1  <= q_in;
            r_q_s2  <= r_q_s1;
            r_cc_s1 <= cnt_clear;
            r_cc_s2 <= r_cc_s1;
        end
    end

    //--------------------------------------------------------------------------
    // Accept logic
    //--------------------------------------------------------------------------
    logic [c_CNT_W-1:0]  r_q_acc;
    logic [c_WRAP_W-1:0] r_wrap_count;
    logic                r_wrap_pulse;
    logic                r_err_skip;

    logic                w_stable;
    logic                w_accept;
    logic                w_wrap;
    logic                w_skip;
    logic [c_CNT_W-1:0]  w_q_succ;

    // Both synchroniser stages agreeing means the value was seen on two
    // consecutive edges; anything shorter is treated as a glitch.
    assign w_stable = (r_q_s2 == r_q_s1);
    assign w_accept = !r_cc_s2 && w_stable && (r_q_s2 != r_q_acc);
    assign w_q_succ = r_q_acc + c_CNT_ONE;
    assign w_wrap   = w_accept && (r_q_acc == c_CNT_MAX) && (r_q_s2 == '0);
    // 15->0 is the modulo-16 successor, so a natural wrap is never a skip.
    assign w_skip   = w_accept && (r_q_s2 != w_q_succ);

    always_ff @(posedge clk) begin
        if (clear) begin
            r_q_acc      <= '0;
            r_wrap_count <= '0;
            r_wrap_pulse <= 1'b0;
            r_err_skip   <= 1'b0;
        end else if (r_cc_s2) begin
            // Upstream counter is being cleared: follow it to zero and
            // suspend acceptance, wrap detection and skip checking.
            r_q_acc      <= '0;
            r_wrap_count <= '0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_wrap_pulse <= w_wrap;
            if (w_accept) begin
                r_q_acc <= r_q_s2;
            end
            if (w_wrap) begin
                r_wrap_count <= r_wrap_count + 1'b1;
            end
            if (w_skip) begin
                r_err_skip <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Snapshot FSM: one held snapshot plus one pending request
    //--------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic                r_snap_valid;
    logic [c_SNAP_W-1:0] r_snap_data;
    logic                r_pending;
    logic                r_overrun;

    // Values are taken before this edge's accept, so a coincident accept is
    // not reflected in the captured snapshot.
    logic [c_SNAP_W-1:0] w_snap_word;
    assign w_snap_word = {r_wrap_count, r_q_acc};

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= c_S_IDLE;
            r_snap_valid <= 1'b0;
            r_snap_data  <= '0;
            r_pending    <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (snap_req) begin
                        r_snap_data  <= w_snap_word;
                        r_snap_valid <= 1'b1;
                        r_state      <= c_S_HOLD;
                    end
                end
                c_S_HOLD: begin
                    if (snap_ready) begin
                        // Completion: serve a queued or coincident request
                        // back-to-back without dropping valid.
                        if (r_pending || snap_req) begin
                            r_snap_data <= w_snap_word;
                            r_pending   <= 1'b0;
                        end else begin
                            r_snap_valid <= 1'b0;
                            r_state      <= c_S_IDLE;
                        end
                    end else if (snap_req) begin
                        if (r_pending) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_snap_valid <= 1'b0;
                    r_pending    <= 1'b0;
                    r_state      <= c_S_IDLE;
                end
            endcase
        end
    end

    assign snap_valid = r_snap_valid;
    assign snap_data  = r_snap_data;
    assign wrap_pulse = r_wrap_pulse;
    assign err_skip   = r_err_skip;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_count_snapshot_unit.sv
`default_nettype none
//==============================================================================
// Module      : tb_count_snapshot_unit
// Description : Directed self-checking bench for count_snapshot_unit.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_count_snapshot_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  q_in;
    logic        cnt_clear;
    logic        snap_req;
    logic        snap_ready;
    logic        snap_valid;
    logic [11:0] snap_data;
    logic        wrap_pulse;
    logic        err_skip;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    count_snapshot_unit dut (
        .clk        (clk),
        .clear      (clear),
        .q_in       (q_in),
        .cnt_clear  (cnt_clear),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .snap_valid (snap_valid),
        .snap_data  (snap_data),
        .wrap_pulse (wrap_pulse),
        .err_skip   (err_skip),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are observed 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
        if (wrap_pulse === 1'b1) pulses++;
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        q_in = v;
        repeat (n) step();
    endtask

    // Request a snapshot, read it while held, then complete the handshake.
    task automatic take_snap(output logic [11:0] d, output logic v);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        d = snap_data;
        v = snap_valid;
        snap_ready = 1'b1;
        step();
        snap_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; q_in = 4'd0; cnt_clear = 1'b0;
        snap_req = 1'b0; snap_ready = 1'b0;
        step(); step();
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", snap_valid); end
        checks++; if (snap_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h expected 000", snap_data); end
        checks++; if (wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_wrap_pulse: got %b expected 0", wrap_pulse); end
        checks++; if (err_skip !== 1'b0) begin errors++; $display("FAIL reset_err_skip: got %b expected 0", err_skip); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (dut.r_q_acc !== 4'd0) begin errors++; $display("FAIL reset_q_acc: got %h expected 0", dut.r_q_acc); end
        clear = 1'b0;
        pulses = 0;
    endtask

    task automatic test_count_wrap();
        logic [3:0]  val;
        logic [11:0] d;
        logic        v;
        pulses = 0;
        for (int n = 1; n <= 16; n++) begin
            val  = n[3:0];
            q_in = val;
            for (int i = 1; i <= 8; i++) begin
                step();
                if (n == 1 && i < 3) begin
                    checks++; if (dut.r_q_acc !== 4'd0) begin errors++; $display("FAIL latency_early_%0d: got %h expected 0", i, dut.r_q_acc); end
                end
                if (n == 1 && i == 3) begin
                    checks++; if (dut.r_q_acc !== 4'd1) begin errors++; $display("FAIL latency_edge2: got %h expected 1", dut.r_q_acc); end
                end
                if (n == 16 && i == 3) begin
                    checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse_timing: got %b expected 1", wrap_pulse); end
                end
            end
            checks++; if (dut.r_q_acc !== val) begin errors++; $display("FAIL follow_%0d: got %h expected %h", n, dut.r_q_acc, val); end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wrap_pulse_count: got %0d expected 1", pulses); end
        checks++; if (err_skip !== 1'b0) begin errors++; $display("FAIL count_err_skip: got %b expected 0", err_skip); end
        take_snap(d, v);
        checks++; if (d !== 12'h010) begin errors++; $display("FAIL count_snap: got %h expected 010", d); end
    endtask

    task automatic test_glitch_skip();
        logic [11:0] d;
        logic        v;
        hold(4'd1, 4); hold(4'd2, 4); hold(4'd3, 4);
        checks++; if (dut.r_q_acc !== 4'd3) begin errors++; $display("FAIL glitch_pre: got %h expected 3", dut.r_q_acc); end
        q_in = 4'd7;
        step();
        hold(4'd4, 6);
        checks++; if (dut.r_q_acc !== 4'd4) begin errors++; $display("FAIL glitch_filter: got %h expected 4", dut.r_q_acc); end
        checks++; if (err_skip !== 1'b0) begin errors++; $display("FAIL glitch_err_skip: got %b expected 0", err_skip); end
        hold(4'd9, 6);
        checks++; if (dut.r_q_acc !== 4'd9) begin errors++; $display("FAIL skip_accept: got %h expected 9", dut.r_q_acc); end
        checks++; if (err_skip !== 1'b1) begin errors++; $display("FAIL skip_err_skip: got %b expected 1", err_skip); end
        take_snap(d, v);
        checks++; if (d !== 12'h019) begin errors++; $display("FAIL skip_snap: got %h expected 019", d); end
    endtask

    task automatic test_upstream_clear();
        logic [11:0] d;
        logic        v;
        pulses = 0;
        repeat (4) begin
            hold(4'd15, 4);
            hold(4'd0, 4);
        end
        hold(4'd10, 4);
        checks++; if (pulses !== 4) begin errors++; $display("FAIL uc_wraps: got %0d expected 4", pulses); end
        take_snap(d, v);
        checks++; if (d !== 12'h05A) begin errors++; $display("FAIL uc_pre_snap: got %h expected 05a", d); end
        pulses = 0;
        q_in = 4'd0;
        cnt_clear = 1'b1;
        repeat (6) step();
        checks++; if (dut.r_q_acc !== 4'd0) begin errors++; $display("FAIL uc_q_acc: got %h expected 0", dut.r_q_acc); end
        cnt_clear = 1'b0;
        repeat (4) step();
        checks++; if (pulses !== 0) begin errors++; $display("FAIL uc_no_pulse: got %0d expected 0", pulses); end
        checks++; if (err_skip !== 1'b1) begin errors++; $display("FAIL uc_err_skip: got %b expected 1", err_skip); end
        take_snap(d, v);
        checks++; if (d !== 12'h000) begin errors++; $display("FAIL uc_snap: got %h expected 000", d); end
    endtask

    task automatic test_handshake();
        repeat (2) begin
            hold(4'd15, 4);
            hold(4'd0, 4);
        end
        hold(4'd6, 4);
        snap_ready = 1'b0;
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        checks++; if (snap_valid !== 1'b1) begin errors++; $display("FAIL hs_valid: got %b expected 1", snap_valid); end
        checks++; if (snap_data !== 12'h026) begin errors++; $display("FAIL hs_data: got %h expected 026", snap_data); end
        q_in = 4'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (snap_valid !== 1'b1 || snap_data !== 12'h026) begin errors++; $display("FAIL hs_hold_%0d: got valid %b data %h expected 1 026", i, snap_valid, snap_data); end
        end
        snap_ready = 1'b1;
        step();
        snap_ready = 1'b0;
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL hs_complete: got %b expected 0", snap_valid); end
        step();
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL hs_idle: got %b expected 0", snap_valid); end
    endtask

    task automatic test_back_to_back();
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        checks++; if (snap_data !== 12'h027) begin errors++; $display("FAIL b2b_first: got %h expected 027", snap_data); end
        hold(4'd8, 4);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_pending_overrun: got %b expected 0", overrun); end
        hold(4'd9, 4);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
        checks++; if (snap_data !== 12'h027) begin errors++; $display("FAIL b2b_hold_data: got %h expected 027", snap_data); end
        snap_ready = 1'b1;
        step();
        checks++; if (snap_valid !== 1'b1 || snap_data !== 12'h029) begin errors++; $display("FAIL b2b_reload: got valid %b data %h expected 1 029", snap_valid, snap_data); end
        step();
        snap_ready = 1'b0;
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", snap_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] d;
        logic        v;
        snap_req = 1'b1; step();
        snap_req = 1'b1; step();
        snap_req = 1'b0;
        checks++; if (snap_valid !== 1'b1 || err_skip !== 1'b1) begin errors++; $display("FAIL rm_precond: got valid %b err %b expected 1 1", snap_valid, err_skip); end
        clear = 1'b1;
        q_in = 4'd0;
        step();
        clear = 1'b0;
        checks++; if ({snap_valid, snap_data, wrap_pulse, err_skip, overrun} !== 16'h0000) begin errors++; $display("FAIL rm_outputs: got v%b d%h w%b e%b o%b expected all 0", snap_valid, snap_data, wrap_pulse, err_skip, overrun); end
        checks++; if (dut.r_q_acc !== 4'd0) begin errors++; $display("FAIL rm_q_acc: got %h expected 0", dut.r_q_acc); end
        hold(4'd1, 4);
        hold(4'd2, 4);
        checks++; if (dut.r_q_acc !== 4'd2) begin errors++; $display("FAIL rm_resume: got %h expected 2", dut.r_q_acc); end
        checks++; if (err_skip !== 1'b0) begin errors++; $display("FAIL rm_err_skip: got %b expected 0", err_skip); end
        take_snap(d, v);
        checks++; if (d !== 12'h002 || v !== 1'b1) begin errors++; $display("FAIL rm_snap: got valid %b data %h expected 1 002", v, d); end
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL rm_pending_dropped: got %b expected 0", snap_valid); end
    endtask

    task automatic test_wrap_modulo();
        logic [11:0] d;
        logic        v;
        pulses = 0;
        repeat (255) begin
            hold(4'd15, 3);
            hold(4'd0, 3);
        end
        checks++; if (pulses !== 255) begin errors++; $display("FAIL mod_pulses: got %0d expected 255", pulses); end
        take_snap(d, v);
        checks++; if (d !== 12'hFF0) begin errors++; $display("FAIL mod_255: got %h expected ff0", d); end
        hold(4'd15, 3);
        hold(4'd0, 3);
        take_snap(d, v);
        checks++; if (d !== 12'h000) begin errors++; $display("FAIL mod_rollover: got %h expected 000", d); end
        checks++; if (pulses !== 256) begin errors++; $display("FAIL mod_pulses_total: got %0d expected 256", pulses); end
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_glitch_skip();
        test_upstream_clear();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        test_wrap_modulo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_snapshot_unit.md
COUNT_SNAPSHOT_UNIT -- requirements
Module: count_snapshot_unit

Interface
REQ-001 SHALL have one clock and one reset; `clear` is synchronous and active-high.
REQ-002 SHALL have these ports, in order:
- clk  in  1  rising-edge clock; frequency SHALL be >= 4x the upstream counter clock.
- clear  in  1  synchronous, active-high reset.
- q_in  in  4  count value from the upstream 4-bit counter; asynchronous to clk, may glitch.
- cnt_clear  in  1  clear signal of the upstream counter; asynchronous to clk.
- snap_req  in  1  one-cycle snapshot request.
- snap_ready  in  1  consumer ready.
- snap_valid  out  1  snapshot available.
- snap_data  out  12  {wrap_count[7:0], q_acc[3:0]}.
- wrap_pulse  out  1  one-cycle pulse on a natural 15->0 wrap.
- err_skip  out  1  sticky flag: non-consecutive count accepted.
- overrun  out  1  sticky flag: snapshot request dropped.

Function
REQ-003 SHALL pass q_in through two flops each cycle (q_s1 <= q_in; q_s2 <= q_s1).
REQ-004 SHALL pass cnt_clear through two flops to produce cc_s.
REQ-005 SHALL accept a new count on any edge where q_s2 == q_s1 and q_s2 != q_acc: q_acc <= q_s2.
- A q_in change first sampled at edge k appears on q_acc at edge k+2.
- Values held for fewer than 2 cycles SHALL be ignored.
REQ-006 While cc_s = 1: q_acc <= 0 and wrap_count <= 0; no wrap_pulse; no err_skip update; accept rule suspended.
REQ-007 On accept with cc_s = 0, old q_acc = 15 and new value = 0:
- wrap_count SHALL increment modulo 256 (255 -> 0).
- wrap_pulse SHALL be 1 for exactly the cycle after that edge.
REQ-008 On accept with cc_s = 0 and new value != (q_acc + 1) mod 16, err_skip SHALL be set; it stays set until clear.
REQ-009 wrap_pulse SHALL be 0 in every cycle not covered by REQ-007.
REQ-010 The snapshot FSM SHALL have two states:
- IDLE: snap_valid = 0.
- HOLD: snap_valid = 1.
REQ-011 In IDLE, snap_req = 1 at an edge SHALL load snap_data <= {wrap_count, q_acc} (pre-edge values) and move to HOLD.
REQ-012 In HOLD, snap_data SHALL stay unchanged until the edge where snap_valid & snap_ready = 1 (completion).
REQ-013 In HOLD without completion, snap_req SHALL set pending; if pending is already 1, it SHALL set overrun instead (sticky until clear).
REQ-014 At completion:
- If pending = 1 or snap_req = 1, snap_data SHALL reload with pre-edge values, pending SHALL clear, and the FSM SHALL stay in HOLD.
- Otherwise the FSM SHALL go to IDLE.
REQ-015 Maximum buffering SHALL be one held snapshot plus one pending request.
REQ-016 An accept (REQ-005) and a snapshot load on the same edge SHALL capture the pre-accept q_acc/wrap_count.

Reset
REQ-017 clear = 1 at an edge SHALL zero all of: q_s1, q_s2, cc_s flops, q_acc, wrap_count, pending, snap_data, snap_valid (FSM to IDLE), wrap_pulse, err_skip, overrun.
REQ-018 clear SHALL take priority over all other inputs; a snapshot in HOLD SHALL be dropped without handshake.
REQ-019 On the first edge after clear deasserts, the block SHALL operate normally with q_acc = 0.

Verification
REQ-020 Count and wrap: q_in steps 0..15, 0, each held 8 clk.
- Expect q_acc to follow with 2-edge latency.
- Expect wrap_count = 1 and exactly one wrap_pulse.
- Expect err_skip = 0.
REQ-021 Glitch and skip filtering:
- q_in 3 -> 7 for 1 cycle -> 4: expect q_acc 3 -> 4 and err_skip = 0.
- Then q_in 4 -> 9 held: expect q_acc = 9 and err_skip = 1.
REQ-022 Upstream clear: wrap_count = 5, q_acc = 10, cnt_clear high 6 cycles while q_in = 0.
- Expect q_acc = 0 and wrap_count = 0.
- Expect no wrap_pulse and err_skip unchanged.
REQ-023 Handshake: snap_req with wrap_count = 2, q_acc = 6, snap_ready low 5 cycles.
- Expect snap_data = 0x026 stable and snap_valid high throughout.
- Expect completion on the first ready edge, then IDLE.
REQ-024 Pending and overrun: three snap_req pulses during one HOLD.
- Expect the second to be served back-to-back at completion with snap_valid staying 1.
- Expect the third to set overrun = 1.
REQ-025 Reset mid-operation: clear for 1 cycle while in HOLD with pending = 1 and err_skip = 1.
- Expect all outputs 0 on the next cycle.
- Expect normal counting to resume.
